// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for the program loader.
// The master modport is the byte source / imem side; the slave modport is the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              imem_wren;

    modport master (
        output in_byte, in_valid,
        input  in_ready, imem_addr, imem_data, imem_wren
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, imem_addr, imem_data, imem_wren
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-serial program loader: packs a big-endian byte stream into imem words and holds
// the processor in reset until the load is complete. Optional feature: IMEM_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] num_words,
    imem_loader_if.slave    bus,
    output logic            proc_reset,
    output logic            done,
    output logic            error
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO  = {(ADDR_W+1){1'b0}};

`ifdef IMEM_CHECKSUM_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CHECK = 2'd2, ST_RUN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd3} state_t;
`endif

    state_t            state_r;
    logic [ADDR_W:0]   num_words_r;
    logic [ADDR_W:0]   word_idx_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       word_r;
    logic              last_r;
    logic              in_ready_r;
    logic              imem_wren_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [DATA_W-1:0] imem_data_r;
    logic              proc_reset_r;
    logic              done_r;
    logic              error_r;
`ifdef IMEM_CHECKSUM_EN
    logic [DATA_W-1:0] csum_acc_r;
`endif

    logic              accept_s;
    logic              start_ok_s;
    logic [DATA_W-1:0] packed_s;

    // in_ready_r is only ever set in LOAD/CHECK, so it alone qualifies a transfer
    assign accept_s   = bus.in_valid & in_ready_r;
    assign start_ok_s = start & ((state_r == ST_IDLE) | (state_r == ST_RUN));
    assign packed_s   = {word_r, bus.in_byte};

    assign bus.in_ready  = in_ready_r;
    assign bus.imem_wren = imem_wren_r;
    assign bus.imem_addr = imem_addr_r;
    assign bus.imem_data = imem_data_r;
    assign proc_reset    = proc_reset_r;
    assign done          = done_r;
    assign error         = error_r;

    // Load sequencer: byte packing, imem write generation and processor hold control
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            num_words_r  <= ZERO;
            word_idx_r   <= ZERO;
            byte_cnt_r   <= 2'd0;
            word_r       <= 24'd0;
            last_r       <= 1'b0;
            in_ready_r   <= 1'b0;
            imem_wren_r  <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_data_r  <= {DATA_W{1'b0}};
            proc_reset_r <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum_acc_r   <= {DATA_W{1'b0}};
`endif
        end else begin
            imem_wren_r <= 1'b0;
            if (start_ok_s) begin
                num_words_r <= num_words;
                word_idx_r  <= ZERO;
                byte_cnt_r  <= 2'd0;
                word_r      <= 24'd0;
                last_r      <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                csum_acc_r  <= {DATA_W{1'b0}};
`endif
                if (num_words == ZERO) begin
                    state_r      <= ST_RUN;
                    in_ready_r   <= 1'b0;
                    proc_reset_r <= 1'b0;
                    done_r       <= 1'b1;
                    error_r      <= 1'b0;
                end else if (num_words > DEPTH) begin
                    state_r      <= ST_IDLE;
                    in_ready_r   <= 1'b0;
                    proc_reset_r <= 1'b1;
                    done_r       <= 1'b0;
                    error_r      <= 1'b1;
                end else begin
                    state_r      <= ST_LOAD;
                    in_ready_r   <= 1'b1;
                    proc_reset_r <= 1'b1;
                    done_r       <= 1'b0;
                    error_r      <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        in_ready_r   <= 1'b0;
                        proc_reset_r <= 1'b1;
                        done_r       <= 1'b0;
                    end
                    ST_LOAD: begin
                        // last_r marks the cycle the final imem write is on the port
                        if (last_r) begin
                            last_r <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                            state_r    <= ST_CHECK;
                            in_ready_r <= 1'b1;
`else
                            state_r      <= ST_RUN;
                            proc_reset_r <= 1'b0;
                            done_r       <= 1'b1;
`endif
                        end else if (accept_s) begin
                            if (byte_cnt_r == 2'd3) begin
                                imem_wren_r <= 1'b1;
                                imem_addr_r <= word_idx_r[ADDR_W-1:0];
                                imem_data_r <= packed_s;
                                word_idx_r  <= word_idx_r + ONE;
                                byte_cnt_r  <= 2'd0;
`ifdef IMEM_CHECKSUM_EN
                                csum_acc_r  <= csum_acc_r + packed_s;
`endif
                                if ((word_idx_r + ONE) == num_words_r) begin
                                    last_r     <= 1'b1;
                                    in_ready_r <= 1'b0;
                                end else begin
                                    last_r     <= 1'b0;
                                end
                            end else begin
                                word_r     <= packed_s[23:0];
                                byte_cnt_r <= byte_cnt_r + 2'd1;
                            end
                        end else begin
                            in_ready_r <= 1'b1;
                        end
                    end
`ifdef IMEM_CHECKSUM_EN
                    ST_CHECK: begin
                        if (accept_s) begin
                            if (byte_cnt_r == 2'd3) begin
                                byte_cnt_r <= 2'd0;
                                in_ready_r <= 1'b0;
                                if (packed_s == csum_acc_r) begin
                                    state_r      <= ST_RUN;
                                    proc_reset_r <= 1'b0;
                                    done_r       <= 1'b1;
                                end else begin
                                    state_r      <= ST_IDLE;
                                    proc_reset_r <= 1'b1;
                                    error_r      <= 1'b1;
                                end
                            end else begin
                                word_r     <= packed_s[23:0];
                                byte_cnt_r <= byte_cnt_r + 2'd1;
                            end
                        end else begin
                            in_ready_r <= 1'b1;
                        end
                    end
`endif
                    ST_RUN: begin
                        in_ready_r   <= 1'b0;
                        proc_reset_r <= 1'b0;
                        done_r       <= 1'b1;
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        in_ready_r   <= 1'b0;
                        proc_reset_r <= 1'b1;
                        done_r       <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed scoreboard bench for imem_loader: expected imem writes are queued as words
// are sent and compared when imem_wren fires.
module tb_imem_loader;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          proc_reset;
    logic          done;
    logic          error;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .bus        (bus.slave),
        .proc_reset (proc_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          checks_failed = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] load_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every imem write must match the oldest queued expectation
    always @(negedge clock) begin
        if (bus.imem_wren === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                check("wren_unexpected", 32'(bus.imem_wren), 32'd0);
            end else begin
                check("imem_addr", 32'(bus.imem_addr), exp_addr_q.pop_front());
                check("imem_data", bus.imem_data, exp_data_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic load_word(input int addr, input logic [31:0] w, input bit gap);
        exp_addr_q.push_back(32'(addr));
        exp_data_q.push_back(w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
            if (gap) @(negedge clock);
        end
        load_sum = load_sum + w;
    endtask

    task automatic send_csum();
`ifdef IMEM_CHECKSUM_EN
        for (int i = 3; i >= 0; i--) send_byte(load_sum[i*8 +: 8]);
`endif
    endtask

    task automatic do_start(input logic [AW:0] n);
        start     = 1'b1;
        num_words = n;
        load_sum  = 32'd0;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),  32'd0);
        check({tag, "_wren"},       32'(bus.imem_wren), 32'd0);
        check({tag, "_addr"},       32'(bus.imem_addr), 32'd0);
        check({tag, "_data"},       bus.imem_data,      32'd0);
        check({tag, "_proc_reset"}, 32'(proc_reset),    32'd1);
        check({tag, "_done"},       32'(done),          32'd0);
        check({tag, "_error"},      32'(error),         32'd0);
    endtask

    initial begin
        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        load_sum     = 32'd0;
        repeat (2) @(negedge clock);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clock);

        // Zero-word load goes straight to RUN with no imem write
        do_start(4'd0);
        check("zero_done",       32'(done),         32'd1);
        check("zero_proc_reset", 32'(proc_reset),   32'd0);
        check("zero_in_ready",   32'(bus.in_ready), 32'd0);

        // Oversize load: error, back to IDLE holding the processor
        do_start(4'(DEPTH + 1));
        check("big_error",      32'(error),      32'd1);
        check("big_proc_reset", 32'(proc_reset), 32'd1);
        check("big_done",       32'(done),       32'd0);
        repeat (2) @(negedge clock);
        check("big_idle_ready", 32'(bus.in_ready), 32'd0);
        check("big_sticky",     32'(error),        32'd1);

        // Basic two-word load
        do_start(4'd2);
        check("err_cleared", 32'(error), 32'd0);
        load_word(0, 32'h2840_0005, 1'b0);
        load_word(1, 32'h2880_0003, 1'b0);
`ifndef IMEM_CHECKSUM_EN
        check("last_wren",    32'(bus.imem_wren), 32'd1);
        check("done_at_wren", 32'(done),          32'd0);
        @(negedge clock);
        check("t1_done",       32'(done),       32'd1);
        check("t1_proc_reset", 32'(proc_reset), 32'd0);
`else
        send_csum();
        wait_done();
`endif
        check("t1_drained", 32'(exp_data_q.size()), 32'd0);

        // Bytes offered in RUN are refused
        bus.in_byte  = 8'hAA;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clock);
        check("run_no_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;

        // Reload from RUN with a gappy source
        do_start(4'd2);
        check("reload_proc_reset", 32'(proc_reset), 32'd1);
        check("reload_done",       32'(done),       32'd0);
        load_word(0, 32'hCAFE_0102, 1'b1);
        load_word(1, 32'h8899_AABB, 1'b1);
        send_csum();
        wait_done();
        check("t2_drained", 32'(exp_data_q.size()), 32'd0);

        // Full-depth load: last address must be DEPTH-1, no wrap
        do_start(4'(DEPTH));
        for (int i = 0; i < DEPTH; i++) load_word(i, 32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b0);
        send_csum();
        wait_done();
        check("depth_drained", 32'(exp_data_q.size()), 32'd0);

        // Reset mid-word discards the partial word
        do_start(4'd2);
        load_word(0, 32'h1122_3344, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_start(4'd1);
        load_word(0, 32'h0BAD_F00D, 1'b0);
        send_csum();
        wait_done();
        check("t4_drained", 32'(exp_data_q.size()), 32'd0);

`ifdef IMEM_CHECKSUM_EN
        // Bad checksum: error, processor held
        do_start(4'd2);
        load_word(0, 32'h0000_0005, 1'b0);
        load_word(1, 32'h0000_0003, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        send_byte(8'h09);
        @(negedge clock);
        check("csum_bad_error",      32'(error),      32'd1);
        check("csum_bad_proc_reset", 32'(proc_reset), 32'd1);
        do_start(4'd2);
        load_word(0, 32'h0000_0005, 1'b0);
        load_word(1, 32'h0000_0003, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        send_byte(8'h08);
        wait_done();
        check("csum_ok_error", 32'(error), 32'd0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
